// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus writes fill a TX FIFO that a
// serializer FSM drains onto txd; STATUS exposes count and flags.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        tx_busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // Bus decode
  logic hit_txdata, hit_status;
  logic push, overflow, ovf_clr, pop;
  logic full, empty;
  logic wdata_unused;

  assign sel          = (addr[31:3] == BASE_ADDR[31:3]);
  assign hit_txdata   = sel && (addr[2:0] == 3'b000);
  assign hit_status   = sel && (addr[2:0] == 3'b100);
  assign wdata_unused = ^writedata[31:8];

  assign push     = memwrite && hit_txdata && !full;
  assign overflow = memwrite && hit_txdata && full;
  assign ovf_clr  = memwrite && hit_status && writedata[3];

  // TX FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       head;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A fresh overflow wins over a clear in the same cycle.
    if (ovf_clr)  ovf_d = 1'b0;
    if (overflow) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= writedata[7:0];
  end

  // Serializer
  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             timer_end;

  assign timer_end = (timer_q == TMR_LAST);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          timer_d = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (timer_end) begin
          timer_d   = '0;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_DATA: begin
        if (timer_end) begin
          timer_d = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_STOP: begin
        if (timer_end) begin
          timer_d = '0;
          // Chain straight into the next start bit when more data waits.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // txd is registered from the next state so the line never glitches.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign txd     = txd_q;
  assign tx_busy = (state_q != ST_IDLE);

  // Register read
  logic [31:0] status;
  assign status = {16'h0000, 8'(count_q), 4'b0000, ovf_q, tx_busy, empty, full};
  assign rdata  = hit_status ? status : 32'h0000_0000;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized and directed bench for mmio_uart_tx against a queue-based
// model of the FIFO and the per-cycle line waveform of each frame.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic        sel, txd, tx_busy;
  logic [31:0] rdata;

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .addr     (addr),
    .writedata(writedata),
    .sel      (sel),
    .rdata    (rdata),
    .txd      (txd),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cycles = 0;

  byte unsigned m_fifo[$];
  bit           m_line[$];
  bit           m_ovf = 1'b0;
  bit           m_txd = 1'b1;
  bit           m_busy = 1'b0;
  bit           m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [7:0] cnt;
    logic       emp, ful;
    cnt = 8'(m_fifo.size());
    emp = (m_fifo.size() == 0);
    ful = (m_fifo.size() == DEPTH);
    return {16'h0000, cnt, 4'h0, m_ovf, m_busy, emp, ful};
  endfunction

  // One rising edge of the reference: frames are whole 10*CPB waveforms,
  // a new one starts as soon as the previous has fully played out.
  task automatic model_edge(input bit rst, input bit mw, input logic [31:0] a,
                            input logic [31:0] wd);
    int           pre;
    byte unsigned b;
    bit           in_win, set_ovf, clr_ovf;
    if (rst) begin
      m_fifo.delete();
      m_line.delete();
      m_ovf   = 1'b0;
      m_txd   = 1'b1;
      m_busy  = 1'b0;
      m_valid = 1'b1;
      return;
    end
    pre = m_fifo.size();
    if (m_line.size() == 0 && pre > 0) begin
      b = m_fifo.pop_front();
      for (int c = 0; c < CPB; c++) m_line.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int c = 0; c < CPB; c++) m_line.push_back(b[i]);
      for (int c = 0; c < CPB; c++) m_line.push_back(1'b1);
    end
    if (m_line.size() > 0) begin
      m_txd  = m_line.pop_front();
      m_busy = 1'b1;
    end else begin
      m_txd  = 1'b1;
      m_busy = 1'b0;
    end
    in_win  = (a[31:3] == BASE[31:3]);
    set_ovf = 1'b0;
    clr_ovf = 1'b0;
    if (mw && in_win && a[2:0] == 3'd0) begin
      if (pre < DEPTH) m_fifo.push_back(wd[7:0]);
      else set_ovf = 1'b1;
    end
    if (mw && in_win && a[2:0] == 3'd4 && wd[3]) clr_ovf = 1'b1;
    if (set_ovf) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endtask

  task automatic tick(input bit rst, input bit mw, input logic [31:0] a, input logic [31:0] wd);
    bit in_win;
    reset     = rst;
    memwrite  = mw;
    addr      = a;
    writedata = wd;
    in_win    = (a[31:3] == BASE[31:3]);
    #1;
    if (m_valid) begin
      check("sel", {31'b0, sel}, {31'b0, in_win});
      check("rdata", rdata, (in_win && a[2:0] == 3'd4) ? m_status() : 32'h0);
    end
    @(posedge clk);
    model_edge(rst, mw, a, wd);
    #1;
    if (m_valid) begin
      check("txd", {31'b0, txd}, {31'b0, m_txd});
      check("tx_busy", {31'b0, tx_busy}, {31'b0, m_busy});
    end
    if (tx_busy === 1'b1) busy_cycles++;
    reset    = 1'b0;
    memwrite = 1'b0;
    addr     = BASE + 32'd4;
    #1;
    if (m_valid) check("status", rdata, m_status());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, BASE + 32'd4, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (m_busy || m_fifo.size() > 0); i++) idle(1);
    idle(2);
    check("drain_idle", {31'b0, tx_busy}, 32'h0);
  endtask

  initial begin
    int          r;
    logic [31:0] a;

    tick(1'b1, 1'b0, BASE, 32'h0);
    tick(1'b1, 1'b1, BASE, 32'h77);
    check("rst_status", rdata, 32'h0000_0002);
    check("rst_txd", {31'b0, txd}, 32'h1);
    idle(3);

    // Single byte frame
    busy_cycles = 0;
    tick(1'b0, 1'b1, BASE, 32'h0000_0055);
    idle(45);
    check("t1_busy_len", busy_cycles, 32'd40);
    check("t1_status", rdata, 32'h0000_0002);

    // Overflow burst
    for (int i = 1; i <= 10; i++) tick(1'b0, 1'b1, BASE, 32'(i));
    check("t2_status", rdata, 32'h0000_080D);

    // Overflow clear
    tick(1'b0, 1'b1, BASE + 32'd4, 32'h0000_0000);
    check("t3_ovf_kept", rdata & 32'hFFFF_FF0F, 32'h0000_080D & 32'hFFFF_FF0F);
    tick(1'b0, 1'b1, BASE + 32'd4, 32'h0000_0008);
    check("t3_ovf_clr", rdata, 32'h0000_0805);
    drain();

    // Back-to-back frames
    busy_cycles = 0;
    tick(1'b0, 1'b1, BASE, 32'h0000_00A5);
    tick(1'b0, 1'b1, BASE, 32'h0000_003C);
    idle(90);
    check("t4_busy_len", busy_cycles, 32'd80);

    // Reset mid-frame
    tick(1'b0, 1'b1, BASE, 32'h0000_00FF);
    idle(15);
    tick(1'b1, 1'b0, BASE + 32'd4, 32'h0);
    check("t5_txd", {31'b0, txd}, 32'h1);
    check("t5_busy", {31'b0, tx_busy}, 32'h0);
    check("t5_status", rdata, 32'h0000_0002);
    busy_cycles = 0;
    idle(50);
    check("t5_quiet", busy_cycles, 32'd0);

    // Out-of-window access
    addr = 32'h0000_0040;
    #1;
    check("t6_sel_out", {31'b0, sel}, 32'h0);
    check("t6_rdata_out", rdata, 32'h0);
    tick(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0055);
    idle(3);
    check("t6_status", rdata, 32'h0000_0002);
    check("t6_txd", {31'b0, txd}, 32'h1);
    addr = BASE;
    #1;
    check("t6_sel_tx", {31'b0, sel}, 32'h1);
    check("t6_rdata_tx", rdata, 32'h0);
    addr = BASE + 32'd8;
    #1;
    check("t6_sel_next", {31'b0, sel}, 32'h0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 30) begin
        tick(1'b0, 1'b1, BASE, $urandom);
      end else if (r < 36) begin
        tick(1'b0, 1'b1, BASE + 32'd4, $urandom);
      end else if (r < 40) begin
        a = BASE + 32'($urandom_range(1, 7));
        tick(1'b0, 1'b1, a, $urandom);
      end else if (r < 44) begin
        a = $urandom;
        tick(1'b0, 1'b1, a, $urandom);
      end else if (r < 45) begin
        tick(1'b1, ($urandom_range(0, 1) == 1), BASE, $urandom);
      end else begin
        tick(1'b0, 1'b0, BASE + 32'd4, 32'h0);
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
